// File: rtl/cpu_run_pkg.sv
// Shared encodings for the CPU run/step controller: FSM states, run modes
// and completion status codes.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    RUN,
    STEP_WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_HALT  = 2'd1,
    MODE_STEP  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    STAT_OK       = 2'd0,
    STAT_TIMEOUT  = 2'd1,
    STAT_ABORTED  = 2'd2,
    STAT_BAD_MODE = 2'd3
  } status_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller for the pipelined CPU: owns the CPU reset and clock
// enable, runs for a count, until halt, or one step at a time.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int RESET_CYCLES = 5,
  parameter int DEFAULT_RUN  = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] run_len,
  input  logic             step,
  input  logic             halt_in,
  input  logic             abort,
  input  logic             reset_req,
  output logic             cpu_rst_n,
  output logic             cpu_en,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

  state_t            state_q, state_d;
  status_t           status_q, status_d;
  mode_t             mode_q;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  len_q, run_cnt;
  logic              en_d, rstn_d, launch, last_en;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst_n(rst_n), .clr(launch), .en(cpu_en), .cnt(cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk(clk), .rst_n(rst_n), .clr(launch), .en(cpu_en), .cnt(run_cnt)
  );

  // True during the enabled cycle that exhausts the latched run length.
  assign last_en = cpu_en && (run_cnt == len_q - CNT_W'(1));

  assign busy   = (state_q == RUN) || (state_q == STEP_WAIT);
  assign done   = (state_q == DONE);
  assign status = status_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_HOLD;
      hold_q    <= '0;
      cpu_en    <= 1'b0;
      cpu_rst_n <= 1'b0;
      status_q  <= STAT_OK;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cpu_en    <= en_d;
      cpu_rst_n <= rstn_d;
      status_q  <= status_d;
    end
  end

  always_ff @(posedge clk) begin
    if (launch) begin
      mode_q <= mode_t'(mode);
      len_q  <= (run_len == '0) ? CNT_W'(DEFAULT_RUN) : run_len;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    en_d     = 1'b0;
    rstn_d   = cpu_rst_n;
    status_d = status_q;
    launch   = 1'b0;
    unique case (state_q)
      RST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
          rstn_d  = 1'b1;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      IDLE, DONE: begin
        if (start) begin
          launch   = 1'b1;
          status_d = STAT_OK;
          unique case (mode_t'(mode))
            MODE_COUNT, MODE_HALT: begin
              state_d = RUN;
              en_d    = 1'b1;
            end
            MODE_STEP: state_d = STEP_WAIT;
            default: begin
              state_d  = DONE;
              status_d = STAT_BAD_MODE;
            end
          endcase
        end
      end
      RUN: begin
        if (abort) begin
          state_d  = DONE;
          status_d = STAT_ABORTED;
        end else if ((mode_q == MODE_HALT) && cpu_en && halt_in) begin
          state_d  = DONE;
          status_d = STAT_OK;
        end else if (last_en) begin
          state_d  = DONE;
          status_d = (mode_q == MODE_HALT) ? STAT_TIMEOUT : STAT_OK;
        end else begin
          en_d = 1'b1;
        end
      end
      STEP_WAIT: begin
        if (abort) begin
          state_d  = DONE;
          status_d = STAT_ABORTED;
        end else if (cpu_en && (halt_in || last_en)) begin
          state_d  = DONE;
          status_d = STAT_OK;
        end else begin
          en_d = step;
        end
      end
      default: state_d = RST_HOLD;
    endcase

    // A soft reset overrides everything but keeps the run's count and status.
    if (reset_req && (state_q != RST_HOLD)) begin
      state_d  = RST_HOLD;
      hold_d   = '0;
      en_d     = 1'b0;
      rstn_d   = 1'b0;
      status_d = status_q;
      launch   = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a countdown-style reference model is checked
// every cycle, and literal expectations pin each scenario's outcome.
module tb_cpu_run_ctrl;

  localparam int CNT_W = 16;
  localparam int RC    = 5;
  localparam int DR    = 22;
  localparam int MAXC  = 65535;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [CNT_W-1:0] run_len = '0;
  logic             step = 1'b0;
  logic             halt_in = 1'b0;
  logic             abort = 1'b0;
  logic             reset_req = 1'b0;
  logic             cpu_rst_n, cpu_en, busy, done;
  logic [1:0]       status;
  logic [CNT_W-1:0] cycle_cnt;

  int total = 0;
  int bad = 0;
  int en_seen = 0;
  int rst_low_seen = 0;

  // reference model: expected outputs after the most recent clock edge
  logic       e_rstn, e_en, e_busy, e_done;
  logic [1:0] e_status, m_mode;
  int         e_cnt, hold_left, left;

  cpu_run_ctrl #(.CNT_W(CNT_W), .RESET_CYCLES(RC), .DEFAULT_RUN(DR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .run_len(run_len),
    .step(step), .halt_in(halt_in), .abort(abort), .reset_req(reset_req),
    .cpu_rst_n(cpu_rst_n), .cpu_en(cpu_en), .busy(busy), .done(done),
    .status(status), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_rstn = 1'b0; e_en = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    e_status = 2'd0; e_cnt = 0; hold_left = RC; left = 0; m_mode = 2'd0;
  endtask

  task automatic finish_run(input logic [1:0] s);
    e_en = 1'b0; e_busy = 1'b0; e_done = 1'b1; e_status = s;
  endtask

  // Advance the model across the next rising edge using the current inputs.
  task automatic model_advance();
    logic was_en;
    if (!e_rstn) begin
      hold_left--;
      if (hold_left == 0) e_rstn = 1'b1;
      return;
    end
    was_en = e_en;
    if (was_en) begin
      if (e_cnt < MAXC) e_cnt++;
      left--;
    end
    if (reset_req) begin
      e_en = 1'b0; e_rstn = 1'b0; hold_left = RC; e_busy = 1'b0; e_done = 1'b0;
      return;
    end
    if (!e_busy) begin
      if (start) begin
        e_cnt = 0; e_status = 2'd0; m_mode = mode;
        left = (run_len == 0) ? DR : int'(run_len);
        if (mode == 2'd3) begin
          e_done = 1'b1; e_status = 2'd3;
        end else begin
          e_done = 1'b0; e_busy = 1'b1; e_en = (mode != 2'd2);
        end
      end
      return;
    end
    if (abort) finish_run(2'd2);
    else if (was_en && halt_in && (m_mode != 2'd0)) finish_run(2'd0);
    else if (left == 0) finish_run((m_mode == 2'd1) ? 2'd1 : 2'd0);
    else e_en = (m_mode == 2'd2) ? step : 1'b1;
  endtask

  // One clock: compare at the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) model_reset();
    chk("cpu_rst_n", cpu_rst_n, e_rstn);
    chk("cpu_en", cpu_en, e_en);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("status", status, e_status);
    chk("cycle_cnt", cycle_cnt, e_cnt);
    chk("busy_done_excl", busy & done, 1'b0);
    chk("en_in_reset", cpu_en & ~cpu_rst_n, 1'b0);
    if (rst_n) begin
      if (cpu_en) en_seen++;
      if (!cpu_rst_n) rst_low_seen++;
      model_advance();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] m, input int l);
    mode = m;
    run_len = CNT_W'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int b;

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("por_rst_low_cycles", rst_low_seen, RC);
    chk("por_no_en", en_seen, 0);
    chk("por_idle", {busy, done, cpu_rst_n}, 3'b001);

    b = en_seen;
    launch(2'd0, 0);
    repeat (25) tick();
    chk("count_default_en", en_seen - b, 22);
    chk("count_default_cnt", cycle_cnt, 22);
    chk("count_default_status", status, 0);
    chk("count_default_done", done, 1);

    b = en_seen;
    launch(2'd0, 1);
    chk("relaunch_busy", {busy, done}, 2'b10);
    repeat (3) tick();
    chk("count_len1_en", en_seen - b, 1);
    chk("count_len1_cnt", cycle_cnt, 1);

    launch(2'd1, 100);
    repeat (8) tick();
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
    chk("halt_en_drop", {cpu_en, done}, 2'b01);
    chk("halt_cnt", cycle_cnt, 9);
    chk("halt_status", status, 0);

    launch(2'd1, 100);
    repeat (102) tick();
    chk("timeout_cnt", cycle_cnt, 100);
    chk("timeout_status", status, 1);

    launch(2'd1, 4);
    repeat (3) tick();
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
    chk("halt_vs_timeout_status", status, 0);
    chk("halt_vs_timeout_cnt", cycle_cnt, 4);

    b = en_seen;
    launch(2'd2, 3);
    for (int i = 0; i < 4; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (3) tick();
    end
    repeat (2) tick();
    chk("step_en_pulses", en_seen - b, 3);
    chk("step_done", done, 1);
    chk("step_cnt", cycle_cnt, 3);

    b = en_seen;
    launch(2'd2, 10);
    step = 1'b1;
    repeat (3) tick();
    step = 1'b0;
    repeat (2) tick();
    chk("step_held_en", en_seen - b, 3);
    chk("step_held_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("step_abort_status", status, 2);

    launch(2'd0, 10);
    repeat (4) tick();
    abort = 1'b1;
    halt_in = 1'b1;
    tick();
    abort = 1'b0;
    halt_in = 1'b0;
    chk("abort_en_drop", cpu_en, 0);
    chk("abort_status", status, 2);
    chk("abort_cnt", cycle_cnt, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_in_done", {done, status}, 3'b110);

    launch(2'd0, 50);
    repeat (6) tick();
    b = rst_low_seen;
    reset_req = 1'b1;
    tick();
    reset_req = 1'b0;
    chk("rstreq_en_drop", {cpu_en, cpu_rst_n}, 2'b00);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("rstreq_low_cycles", rst_low_seen - b, RC);
    chk("rstreq_cnt_kept", cycle_cnt, 7);
    chk("rstreq_idle", {busy, done, cpu_rst_n}, 3'b001);

    b = en_seen;
    launch(2'd3, 5);
    repeat (3) tick();
    chk("badmode_en", en_seen - b, 0);
    chk("badmode_status", status, 3);
    chk("badmode_done", done, 1);
    chk("badmode_cnt", cycle_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Synthesizable run/step controller between the board clock domain and the pipelined LEGv8 `cpu` top.
- Generates the CPU-side reset (`cpu_rst_n`) and a clock-enable (`cpu_en`) so the CPU runs in one of three modes:
  - a fixed number of cycles,
  - until the CPU raises halt,
  - single-stepped.
- Counts executed cycles and reports completion status, so benches and on-board debug share one run mechanism.

Parameters:
- CNT_W, 16, width of run length and cycle counter.
- RESET_CYCLES, 5, cycles `cpu_rst_n` is held low after any reset request (≥1).
- DEFAULT_RUN, 22, run length used when `run_len` = 0 at start.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  launch pulse, sampled in IDLE/DONE only.
- mode  in  2  0=COUNT, 1=HALT, 2=STEP, 3=reserved; latched on start.
- run_len  in  CNT_W  cycles (COUNT), step count (STEP), timeout (HALT); latched on start.
- step  in  1  single-cycle advance pulse, honoured in STEP mode only.
- halt_in  in  1  CPU halt indication.
- abort  in  1  terminate the current run.
- reset_req  in  1  soft reset request for the CPU.
- cpu_rst_n  out  1  registered active-low reset to the CPU.
- cpu_en  out  1  registered CPU clock-enable.
- busy  out  1  high in RUN/STEP_WAIT.
- done  out  1  high while in DONE.
- status  out  2  0=OK, 1=TIMEOUT, 2=ABORTED, 3=BAD_MODE.
- cycle_cnt  out  CNT_W  count of cycles with cpu_en=1 since last start; saturates at all-ones.

Behaviour:
- **Async reset (`rst_n`=0):**
  - Outputs: `cpu_rst_n`=0, `cpu_en`=0, `busy`=0, `done`=0, `status`=0, `cycle_cnt`=0.
  - State: RST_HOLD, hold counter=0.
- **RST_HOLD:**
  - `cpu_rst_n`=0 for exactly RESET_CYCLES clocks after entry, then goes to 1 and the FSM enters IDLE.
  - `start`, `step` and `abort` are ignored here.
- **IDLE/DONE, `start`=1:**
  - Latch `mode`; latch `run_len`, substituting DEFAULT_RUN when `run_len`=0.
  - Clear `cycle_cnt`; set `status`=0; clear `done`.
  - mode 3: set `status`=BAD_MODE and go to DONE; `cpu_en` never asserts.
  - COUNT/HALT: go to RUN; `cpu_en`=1 from the cycle after `start`.
  - STEP: go to STEP_WAIT.
- **RUN, COUNT mode:**
  - `cpu_en` is high for exactly `len` consecutive cycles.
  - DONE is entered on the cycle `cpu_en` falls; `status`=OK.
- **RUN, HALT mode:**
  - `halt_in` sampled high while `cpu_en`=1 drops `cpu_en` on the next cycle and enters DONE with OK.
  - The halting cycle is counted.
  - If `len` cycles elapse without halt, enter DONE with TIMEOUT.
  - Simultaneous halt and timeout resolves to OK.
- **STEP_WAIT:**
  - Each `step` pulse produces exactly one `cpu_en` cycle, on the next clock.
  - A `step` held high for k cycles produces k enables.
  - After `len` enables, enter DONE with OK.
  - `halt_in` during a stepped cycle also ends the run with OK.
- **`cycle_cnt`:** increments every cycle `cpu_en`=1; holds at 2^CNT_W−1.
- **`abort`** (RUN/STEP_WAIT):
  - `cpu_en`=0 next cycle; enter DONE with ABORTED.
  - Abort has priority over halt, timeout and completion in the same cycle.
  - In IDLE/DONE, abort has no effect.
- **`reset_req`** (any state except RST_HOLD):
  - Highest priority: `cpu_en`=0 next cycle; enter RST_HOLD.
  - `cycle_cnt` and `status` keep their values; `done`=0.
- **DONE:**
  - `done` stays high until the next `start` or `reset_req`.
  - `start` in DONE relaunches without re-resetting the CPU.
- `busy` and `done` are never high together. `cpu_en` is never high while `cpu_rst_n`=0.

Decomposition:
- Package `cpu_run_pkg`: state enum (RST_HOLD, IDLE, RUN, STEP_WAIT, DONE), mode encodings, status encodings.
- One sub-module, `sat_counter` (parametrised width, enable, sync clear, saturate).
  - Instantiated for `cycle_cnt` and for the run-length counter.
  - The reset-hold counter is a local counter inside `cpu_run_ctrl`.

Test Plan:
- Power-on: `rst_n` low 3 cycles then high → `cpu_rst_n` low for exactly 5 cycles after release, then high; `cpu_en`=0 throughout.
- COUNT, `run_len`=0: `start` → `cpu_en` high exactly 22 cycles; then `done`=1, `status`=0, `cycle_cnt`=22.
- HALT, `run_len`=100: `halt_in` raised on 9th enabled cycle → `cpu_en` low next cycle, `cycle_cnt`=9, `status`=OK. Same with no halt → `cycle_cnt`=100, `status`=TIMEOUT.
- STEP, `run_len`=3: pulses spaced 4 cycles → exactly 3 single `cpu_en` pulses one cycle after each step, then `done`. Extra step after done → no `cpu_en`.
- `abort` on 5th cycle of COUNT `run_len`=10, same cycle as a `reset_req`-free halt → `status`=ABORTED, `cycle_cnt`=5, `cpu_en` low next cycle.
- `reset_req` mid-RUN → `cpu_en` low next cycle, `cpu_rst_n` low 5 cycles, FSM in IDLE. `mode`=3 start → `status`=BAD_MODE, `cpu_en` never high.
